// File: rtl/adr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adr_arb_pkg
// Purpose  : Shared definitions for the address-bus arbiter: FSM state
//            encodings, default parameter values and the pointer-width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package adr_arb_pkg;

  localparam int NREQ_DEF    = 4;
  localparam int AW_DEF      = 4;
  localparam int TMO_CYC_DEF = 15;

  // FSM encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  // Width of a requester index / round-robin pointer; never narrower than 1
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adr_bus_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin pick. Searches req starting at index
//            rr_ptr and wrapping, returning the first set bit.
// Ports    : req     [NREQ-1:0] requests
//            rr_ptr  [PW-1:0]   search start index
//            win     [NREQ-1:0] one-hot winner (zero when req is zero)
//            win_idx [PW-1:0]   winner index (zero when req is zero)
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
  import adr_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int PW   = ptr_w(NREQ_DEF)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  output logic [NREQ-1:0] win,
  output logic [PW-1:0]   win_idx
);

  always_comb begin : p_pick
    logic          w_found;
    logic [PW-1:0] w_j;
    win     = '0;
    win_idx = '0;
    w_found = 1'b0;
    w_j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      // Candidate k positions after the pointer, wrapped into range
      w_j = PW'((int'(rr_ptr) + k) % NREQ);
      if (!w_found && req[w_j]) begin
        w_found = 1'b1;
        win[w_j] = 1'b1;
        win_idx  = w_j;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/adr_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : adr_bus_arbiter
// Purpose  : Round-robin arbiter granting one of NREQ requesters ownership of
//            a shared address bus for a burst of beats.
// Ports    : clk, rst_n (async, active-low)
//            req[NREQ]        level requests
//            req_adr[NREQ*AW] per-requester address, slice i = [i*AW +: AW]
//            req_last[NREQ]   current beat of requester i is its last
//            gnt[NREQ]        registered one-hot grant
//            adr[AW], adr_vld shared bus toward the consumer
//            adr_rdy          consumer accepts the beat
//            busy             a grant is held
//            tmo_err          one-cycle pulse on forced release
// Options  : ADR_BUS_ARBITER_TIMEOUT_EN - builds the stall watchdog that forces
//            a release after TMO_CYC consecutive stalled cycles; otherwise
//            tmo_err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module adr_bus_arbiter
  import adr_arb_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int AW      = AW_DEF,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_adr,
  input  logic [NREQ-1:0]    req_last,
  output logic [NREQ-1:0]    gnt,
  output logic [AW-1:0]      adr,
  output logic               adr_vld,
  input  logic               adr_rdy,
  output logic               busy,
  output logic               tmo_err
);

  localparam int PW = ptr_w(NREQ);

  logic [0:0]      r_state;
  logic [NREQ-1:0] r_gnt;
  logic [PW-1:0]   r_owner;
  logic [PW-1:0]   r_rr_ptr;

  logic [NREQ-1:0] w_win;
  logic [PW-1:0]   w_win_idx;
  logic            w_own;
  logic            w_own_req;
  logic            w_xfer;
  logic            w_tmo;
  logic            w_release;
  logic [PW-1:0]   w_next_ptr;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .req     (req),
    .rr_ptr  (r_rr_ptr),
    .win     (w_win),
    .win_idx (w_win_idx)
  );

  assign w_own     = (r_state == ST_OWN);
  assign w_own_req = req[r_owner];
  assign adr_vld   = w_own & w_own_req;
  assign adr       = w_own ? req_adr[r_owner*AW +: AW] : '0;
  assign w_xfer    = adr_vld & adr_rdy;

  // Leave OWN on the last accepted beat, when the owner withdraws, or on timeout
  assign w_release = w_own & ((w_xfer & req_last[r_owner]) | ~w_own_req | w_tmo);

  assign w_next_ptr = (r_owner == PW'(NREQ - 1)) ? '0 : r_owner + 1'b1;

`ifdef ADR_BUS_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TMO_CYC + 1);

  logic [CW-1:0] r_stall;
  logic          w_stall;

  assign w_stall = adr_vld & ~adr_rdy;
  // Fires during the TMO_CYC-th consecutive stalled cycle
  assign w_tmo   = w_stall && (r_stall == CW'(TMO_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall <= '0;
    end else if (w_stall && !w_tmo) begin
      r_stall <= r_stall + 1'b1;
    end else begin
      r_stall <= '0;
    end
  end
`else
  // Watchdog not built; TMO_CYC stays in the parameter list for compatibility
  assign w_tmo = (TMO_CYC < 0);
`endif

  assign tmo_err = w_tmo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_gnt    <= '0;
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_state <= ST_OWN;
            r_gnt   <= w_win;
            r_owner <= w_win_idx;
          end
        end
        ST_OWN: begin
          // New requests are ignored here; they are arbitrated back in IDLE
          if (w_release) begin
            r_state  <= ST_IDLE;
            r_gnt    <= '0;
            r_rr_ptr <= w_next_ptr;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  assign gnt  = r_gnt;
  assign busy = w_own;

endmodule
`default_nettype wire
